// File: rtl/risc16_pkg.sv
// Shared definitions for the RISC16 fetch front end.
//   WORD_W   : datapath / address width
//   RESET_PC : program counter value after reset
//   PC_STEP  : PC increment per fetched word (word-addressed memory)
//   fetch_state_t : fetch controller state encoding
package risc16_pkg;
  localparam int WORD_W = 16;
  localparam logic [WORD_W-1:0] RESET_PC = '0;
  localparam int PC_STEP = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/pc_reg.sv
// Program counter register.
//   clk, rst_n : clock, async active-low reset (resets to RESET_PC)
//   load       : take load_val next cycle (priority over inc)
//   inc        : advance by PC_STEP next cycle, wraps modulo 2^WORD_W
//   pc         : current program counter
module pc_reg #(
  parameter int                WORD_W   = risc16_pkg::WORD_W,
  parameter logic [WORD_W-1:0] RESET_PC = risc16_pkg::RESET_PC,
  parameter logic [WORD_W-1:0] PC_STEP  = WORD_W'(risc16_pkg::PC_STEP)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              inc,
  input  logic [WORD_W-1:0] load_val,
  output logic [WORD_W-1:0] pc
);
  import risc16_pkg::*;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pc <= RESET_PC;
    else if (load) pc <= load_val;
    else if (inc)  pc <= pc + PC_STEP;
  end
endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller feeding the 16-bit instruction register.
// Owns the PC, runs a req/ready handshake with instruction memory and
// delivers each word on ir_data with a one-cycle ir_load strobe.
//   clk, rst_n          : clock, async active-low reset
//   en                  : fetch enable (an outstanding request still completes)
//   stall               : downstream cannot take ir_load this cycle
//   redirect_valid/_pc  : branch/jump target pulse
//   imem_req/addr       : memory request, address = PC (decoded from state)
//   imem_ready/rdata    : memory response
//   ir_data/ir_load     : word and load strobe to the instruction register
//   pc_out              : address of the word on ir_data
//   busy                : controller not idle
module fetch_ctrl #(
  parameter int                WORD_W   = risc16_pkg::WORD_W,
  parameter logic [WORD_W-1:0] RESET_PC = risc16_pkg::RESET_PC,
  parameter int                PC_STEP  = risc16_pkg::PC_STEP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic [WORD_W-1:0] ir_data,
  output logic              ir_load,
  output logic [WORD_W-1:0] pc_out,
  output logic              busy
);
  import risc16_pkg::*;

  localparam logic [WORD_W-1:0] STEP = WORD_W'(PC_STEP);

  fetch_state_t      state;
  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] pc_val;
  logic              pc_load, pc_inc;
  logic [WORD_W-1:0] hold_data, hold_pc;
  logic              pend_vld;
  logic [WORD_W-1:0] pend_pc;
  logic              fire;

  assign fire      = (state == REQ) && imem_ready;
  assign imem_req  = (state == REQ);
  assign imem_addr = pc;
  assign busy      = (state != IDLE);

  // PC update. A redirect seen mid-request is parked in pend_pc and only
  // applied when the request completes, so imem_addr stays stable.
  // A same-cycle redirect beats the parked one.
  always_comb begin
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    pc_val  = redirect_pc;
    case (state)
      IDLE: pc_load = redirect_valid;
      REQ: begin
        if (fire) begin
          if (redirect_valid) begin
            pc_load = 1'b1;
          end else if (pend_vld) begin
            pc_load = 1'b1;
            pc_val  = pend_pc;
          end else begin
            pc_inc = 1'b1;
          end
        end
      end
      HOLD: pc_load = redirect_valid;
      default: ;
    endcase
  end

  pc_reg #(
    .WORD_W   (WORD_W),
    .RESET_PC (RESET_PC),
    .PC_STEP  (STEP)
  ) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (pc_load),
    .inc      (pc_inc),
    .load_val (pc_val),
    .pc       (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ir_data   <= '0;
      pc_out    <= '0;
      ir_load   <= 1'b0;
      hold_data <= '0;
      hold_pc   <= '0;
      pend_vld  <= 1'b0;
      pend_pc   <= '0;
    end else begin
      ir_load <= 1'b0;
      case (state)
        IDLE: begin
          if (en) state <= REQ;
        end
        REQ: begin
          if (fire) begin
            if (redirect_valid || pend_vld) begin
              // wrong-path word: drop it
              pend_vld <= 1'b0;
              state    <= en ? REQ : IDLE;
            end else if (stall) begin
              hold_data <= imem_rdata;
              hold_pc   <= pc;
              state     <= HOLD;
            end else begin
              ir_data <= imem_rdata;
              pc_out  <= pc;
              ir_load <= 1'b1;
              state   <= en ? REQ : IDLE;
            end
          end else if (redirect_valid) begin
            pend_vld <= 1'b1;
            pend_pc  <= redirect_pc;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            state <= en ? REQ : IDLE;
          end else if (!stall) begin
            ir_data <= hold_data;
            pc_out  <= hold_pc;
            ir_load <= 1'b1;
            state   <= en ? REQ : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
